// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1x3 router control path.
// Provides:
//   state_e         3-bit FSM state encodings
//   ADDR_INVALID    header address that drops a packet
//   strobes_t       bundle of the Moore outputs of router_fsm
//   decode_strobes  state -> strobe decode
//   pick_port       select one of three per-port flags by address
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_e;

    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef struct packed {
        logic busy;
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic rst_int_reg;
        logic write_enb_reg;
    } strobes_t;

    // Moore output decode for a given state.
    function automatic strobes_t decode_strobes(input state_e s);
        strobes_t r;
        r               = '0;
        r.detect_add    = (s == DECODE_ADDRESS);
        r.lfd_state     = (s == LOAD_FIRST_DATA);
        r.ld_state      = (s == LOAD_DATA);
        r.laf_state     = (s == LOAD_AFTER_FULL);
        r.full_state    = (s == FIFO_FULL_STATE);
        r.rst_int_reg   = (s == CHECK_PARITY_ERROR);
        r.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) ||
                          (s == LOAD_AFTER_FULL);
        r.busy          = !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
        return r;
    endfunction

    // Per-port flag select; address 3 has no port and reads as 0.
    function automatic logic pick_port(input logic [2:0] flags, input logic [1:0] sel);
        logic r;
        case (sel)
            2'd0:    r = flags[0];
            2'd1:    r = flags[1];
            2'd2:    r = flags[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Signal bundle between router_fsm and its surroundings (source,
// synchronizer/FIFOs, router_reg).
//   slave  : the FSM side (consumes status, drives strobes)
//   master : the environment side (drives status, consumes strobes)
interface router_fsm_if;
    logic       packet_valid;
    logic [1:0] datain;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;

    modport slave (
        input  packet_valid, datain, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_packet_valid,
        output busy, detect_add, lfd_state, ld_state, laf_state,
        output full_state, rst_int_reg, write_enb_reg
    );

    modport master (
        output packet_valid, datain, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_packet_valid,
        input  busy, detect_add, lfd_state, ld_state, laf_state,
        input  full_state, rst_int_reg, write_enb_reg
    );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router. Sequences header decode, wait for the
// destination FIFO to drain, first-data / payload / parity loading and
// FIFO-full stalls, and aborts to DECODE_ADDRESS on the selected port's
// soft reset.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     router_fsm_if.slave: status inputs and state strobes
// All strobes come straight from flops (next-state decode registered), so
// they carry the Moore timing of the state register with no
// input-to-output combinational path.
module router_fsm
    import router_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    router_fsm_if.slave  bus
);

    state_e     state_q, state_d, state_nxt_s;
    logic [1:0] addr_q, addr_d;
    strobes_t   strobes_q;
    logic [2:0] empty_vec_s;
    logic [2:0] srst_vec_s;
    logic       sel_empty_s;
    logic       live_empty_s;
    logic       soft_sel_s;

    assign empty_vec_s  = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign srst_vec_s   = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    // Latched address for waiting/soft reset; live header address for decode.
    assign sel_empty_s  = pick_port(empty_vec_s, addr_q);
    assign live_empty_s = pick_port(empty_vec_s, bus.datain);
    assign soft_sel_s   = pick_port(srst_vec_s, addr_q);

    // Next-state and address-latch decode.
    always_comb begin
        state_nxt_s = state_q;
        addr_d      = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.packet_valid) begin
                    addr_d = bus.datain;
                    if (bus.datain == ADDR_INVALID) begin
                        state_nxt_s = DECODE_ADDRESS;
                    end else if (live_empty_s) begin
                        state_nxt_s = LOAD_FIRST_DATA;
                    end else begin
                        state_nxt_s = WAIT_TILL_EMPTY;
                    end
                end else begin
                    state_nxt_s = DECODE_ADDRESS;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty_s) begin
                    state_nxt_s = LOAD_FIRST_DATA;
                end else begin
                    state_nxt_s = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_nxt_s = LOAD_DATA;
            LOAD_DATA: begin
                // A full FIFO wins over the end of the packet.
                if (bus.fifo_full) begin
                    state_nxt_s = FIFO_FULL_STATE;
                end else if (!bus.packet_valid) begin
                    state_nxt_s = LOAD_PARITY;
                end else begin
                    state_nxt_s = LOAD_DATA;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    state_nxt_s = LOAD_AFTER_FULL;
                end else begin
                    state_nxt_s = FIFO_FULL_STATE;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    state_nxt_s = DECODE_ADDRESS;
                end else if (bus.low_packet_valid) begin
                    state_nxt_s = LOAD_PARITY;
                end else begin
                    state_nxt_s = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_nxt_s = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (bus.fifo_full) begin
                    state_nxt_s = FIFO_FULL_STATE;
                end else begin
                    state_nxt_s = DECODE_ADDRESS;
                end
            end
            default: state_nxt_s = DECODE_ADDRESS;
        endcase

        // Selected-port soft reset overrides every other transition.
        if ((state_q != DECODE_ADDRESS) && soft_sel_s) begin
            state_d = DECODE_ADDRESS;
        end else begin
            state_d = state_nxt_s;
        end
    end

    // State, address latch and registered strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DECODE_ADDRESS;
            addr_q    <= 2'd0;
            strobes_q <= decode_strobes(DECODE_ADDRESS);
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            strobes_q <= decode_strobes(state_d);
        end
    end

    assign bus.busy          = strobes_q.busy;
    assign bus.detect_add    = strobes_q.detect_add;
    assign bus.lfd_state     = strobes_q.lfd_state;
    assign bus.ld_state      = strobes_q.ld_state;
    assign bus.laf_state     = strobes_q.laf_state;
    assign bus.full_state    = strobes_q.full_state;
    assign bus.rst_int_reg   = strobes_q.rst_int_reg;
    assign bus.write_enb_reg = strobes_q.write_enb_reg;

endmodule
